rob_ring: RTL and testbench
===========================

Name: rob_ring

Overview:
Parametrised reorder buffer, the successor to the fixed 8-entry ROB. It uses a circular queue with explicit occupancy count and configurable depth, and accepts NUM_WB independent write-back channels (CDB, ALU, ...). It also provides registered in-order commit to the register file, store release to the LSB, and branch resolution with a self-generated flush/redirect. It sits between decoder/issue and RF/RS/LSB/predictor.

Parameters:
DEPTH_LOG, 3, log2 of entry count (DEPTH = 2**DEPTH_LOG)
NUM_WB, 2, number of write-back channels
VAL_W, 32, result width
ADDR_W, 32, PC width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = hold all state
issue_valid  in  1  decoder presents an instruction
issue_type  in  2  00 REG, 01 STORE, 10 BRANCH, 11 reserved (treated as REG)
issue_rd  in  REG_W  destination register (REG only)
issue_pc  in  ADDR_W  instruction PC
issue_target  in  ADDR_W  branch target
issue_pred  in  1  predicted taken
issue_ready  out  1  entry available this cycle
issue_tag  out  DEPTH_LOG  tag assigned on acceptance (= tail)
wb_valid  in  NUM_WB  per-channel result valid
wb_tag  in  NUM_WB*DEPTH_LOG  packed tags, channel 0 in LSBs
wb_val  in  NUM_WB*VAL_W  packed results; for BRANCH, bit0 = actual taken
q_tag1, q_tag2  in  DEPTH_LOG  operand lookup tags
q_rdy1, q_rdy2  out  1  entry result available
q_val1, q_val2  out  VAL_W  entry result
commit_valid  out  1  one-cycle pulse: register write
commit_rd  out  REG_W  register written
commit_val  out  VAL_W  value written
commit_tag  out  DEPTH_LOG  tag retired (RF clears rename if matching)
store_valid  out  1  one-cycle pulse: store may go to memory
store_tag  out  DEPTH_LOG  tag of released store
bp_update  out  1  one-cycle pulse: branch retired
bp_pc  out  ADDR_W  retired branch PC
bp_taken  out  1  actual direction
flush_out  out  1  one-cycle mispredict pulse
redirect_pc  out  ADDR_W  correct fetch PC, valid with flush_out
empty  out  1  count == 0

Behaviour:
- Reset (rst_in high at posedge): head = tail = count = 0; all entry busy/ready bits 0. Every output register is 0; all pulses low.
- rdy_in low: no state change; issue_ready = 0; pulse outputs deassert next edge.
- Accept condition: issue_ready = rdy_in && count != DEPTH && !flush_out. Acceptance = issue_valid && issue_ready.
- Full is evaluated on current count: a same-cycle commit does not free a slot for that cycle's issue.
- On acceptance: entry[tail] = {busy=1, ready=0, fields}; tail wraps DEPTH-1 -> 0.
- Write-back: for each channel with wb_valid and busy target entry, set ready = 1 and latch value. Writes to non-busy entries are ignored. If multiple channels hit the same tag in one cycle, the highest channel index wins.
- Commit, at most one per cycle: when entry[head] is busy && ready, retire it, clear busy, advance head with wrap, and decrement count. Outputs are registered (1-cycle latency from ready observed at head).
  - REG: commit_valid = 1 only if rd != 0; commit_rd/val/tag from entry.
  - STORE: store_valid = 1, store_tag = head.
  - BRANCH: bp_update = 1, bp_pc = pc, bp_taken = val[0]. If val[0] != pred: flush_out = 1, redirect_pc = val[0] ? target : pc + 4 (mod 2**ADDR_W).
- Write-back arriving at head in the same cycle commits the following cycle (no same-cycle bypass into commit).
- Flush: in the cycle flush_out is high, all entries are cleared, head = tail = count = 0, and write-backs and issue are discarded. Pulse outputs other than flush_out/bp_* are 0 in that cycle.
- count update: +1 on accept, -1 on commit, unchanged when both occur.
- Lookup: q_rdy = busy && ready of entry[q_tag]; q_val = entry value; combinational.

Optional Feature:
ROB_WB_BYPASS_EN
- Defined: lookup ports also match the current-cycle wb_valid/wb_tag (highest channel wins) and return q_rdy = 1 with the wb value, provided the entry is busy.
- Undefined: lookup reflects registered entry state only; a result becomes visible one cycle after write-back.

Test Plan:
- Reset, then issue 8 REG (DEPTH_LOG=3) with no write-back -> issue_tag 0..7, issue_ready = 0 after 8th, empty = 0; 9th issue_valid ignored.
- Issue tags 0,1 (rd=5,6); wb tag1 = 0x22 then tag0 = 0x11 -> commit tag0 (rd5, 0x11) then tag1 (rd6, 0x22) on consecutive cycles, in order.
- Both channels write tag 3 same cycle, ch0 = 0xA, ch1 = 0xB -> committed value 0xB.
- BRANCH pc=0x100, target=0x180, pred=0, wb val=1 -> bp_update, bp_taken = 1, flush_out pulse, redirect_pc = 0x180; next cycle empty = 1, issue_tag = 0.
- Fill to full, retire one while issuing in same cycle -> issue refused that cycle, accepted next; tail wraps 7 -> 0.
- With ROB_WB_BYPASS_EN: wb tag2 = 0x55 while q_tag1 = 2 -> q_rdy1 = 1, q_val1 = 0x55 same cycle; without it, both visible one cycle later.

Source files
------------

// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer with NUM_WB write-back channels, in-order commit,
// store release and branch resolution with self-generated flush. Optional macro: ROB_WB_BYPASS_EN.
module rob_ring #(
   parameter int DEPTH_LOG = 3,
   parameter int NUM_WB    = 2,
   parameter int VAL_W     = 32,
   parameter int ADDR_W    = 32,
   parameter int REG_W     = 5
) (
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        issue_valid,
   input  logic [1:0]                  issue_type,
   input  logic [REG_W-1:0]            issue_rd,
   input  logic [ADDR_W-1:0]           issue_pc,
   input  logic [ADDR_W-1:0]           issue_target,
   input  logic                        issue_pred,
   output logic                        issue_ready,
   output logic [DEPTH_LOG-1:0]        issue_tag,
   input  logic [NUM_WB-1:0]           wb_valid,
   input  logic [NUM_WB*DEPTH_LOG-1:0] wb_tag,
   input  logic [NUM_WB*VAL_W-1:0]     wb_val,
   input  logic [DEPTH_LOG-1:0]        q_tag1,
   input  logic [DEPTH_LOG-1:0]        q_tag2,
   output logic                        q_rdy1,
   output logic                        q_rdy2,
   output logic [VAL_W-1:0]            q_val1,
   output logic [VAL_W-1:0]            q_val2,
   output logic                        commit_valid,
   output logic [REG_W-1:0]            commit_rd,
   output logic [VAL_W-1:0]            commit_val,
   output logic [DEPTH_LOG-1:0]        commit_tag,
   output logic                        store_valid,
   output logic [DEPTH_LOG-1:0]        store_tag,
   output logic                        bp_update,
   output logic [ADDR_W-1:0]           bp_pc,
   output logic                        bp_taken,
   output logic                        flush_out,
   output logic [ADDR_W-1:0]           redirect_pc,
   output logic                        empty
);
   localparam int DEPTH = 2**DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};
   localparam logic [1:0] T_STORE  = 2'b01;
   localparam logic [1:0] T_BRANCH = 2'b10;

   logic [DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d;
   logic [1:0]           type_q [DEPTH];
   logic [REG_W-1:0]     rd_q   [DEPTH];
   logic [ADDR_W-1:0]    pc_q   [DEPTH];
   logic [ADDR_W-1:0]    tgt_q  [DEPTH];
   logic                 pred_q [DEPTH];
   logic [VAL_W-1:0]     val_q  [DEPTH];
   logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
   logic [DEPTH_LOG:0]   count_q, count_d;

   logic [DEPTH-1:0]     wb_hit;
   logic [VAL_W-1:0]     wb_data [DEPTH];
   logic                 accept, do_commit, head_taken;

   assign issue_ready = rdy_in && (count_q != FULL_CNT) && !flush_out;
   assign accept      = issue_valid && issue_ready;
   assign do_commit   = rdy_in && !flush_out && busy_q[head_q] && ready_q[head_q];
   assign issue_tag   = tail_q;
   assign empty       = (count_q == '0);
   assign head_taken  = val_q[head_q][0];

   // Resolve write-back channels per entry; later (higher) channels override earlier ones.
   always_comb begin
      wb_hit = '0;
      for (int e = 0; e < DEPTH; e++) wb_data[e] = '0;
      for (int c = 0; c < NUM_WB; c++) begin
         if (wb_valid[c]) begin
            wb_hit[wb_tag[c*DEPTH_LOG +: DEPTH_LOG]]  = 1'b1;
            wb_data[wb_tag[c*DEPTH_LOG +: DEPTH_LOG]] = wb_val[c*VAL_W +: VAL_W];
         end
      end
   end

   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      for (int e = 0; e < DEPTH; e++)
         if (wb_hit[e] && busy_q[e]) ready_d[e] = 1'b1;
      if (do_commit) begin
         busy_d[head_q]  = 1'b0;
         ready_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (accept) begin
         busy_d[tail_q]  = 1'b1;
         ready_d[tail_q] = 1'b0;
         tail_d          = tail_q + 1'b1;
      end
      if (accept && !do_commit)      count_d = count_q + 1'b1;
      else if (!accept && do_commit) count_d = count_q - 1'b1;
   end

   always_comb begin
      q_rdy1 = busy_q[q_tag1] && ready_q[q_tag1];
      q_val1 = val_q[q_tag1];
      q_rdy2 = busy_q[q_tag2] && ready_q[q_tag2];
      q_val2 = val_q[q_tag2];
`ifdef ROB_WB_BYPASS_EN
      if (busy_q[q_tag1] && wb_hit[q_tag1]) begin
         q_rdy1 = 1'b1;
         q_val1 = wb_data[q_tag1];
      end
      if (busy_q[q_tag2] && wb_hit[q_tag2]) begin
         q_rdy2 = 1'b1;
         q_val2 = wb_data[q_tag2];
      end
`endif
   end

   // Entry payload: no reset needed, validity is carried by busy/ready.
   always_ff @(posedge clk) begin
      if (rdy_in && !flush_out) begin
         for (int e = 0; e < DEPTH; e++)
            if (wb_hit[e] && busy_q[e]) val_q[e] <= wb_data[e];
      end
      if (accept) begin
         type_q[tail_q] <= issue_type;
         rd_q[tail_q]   <= issue_rd;
         pc_q[tail_q]   <= issue_pc;
         tgt_q[tail_q]  <= issue_target;
         pred_q[tail_q] <= issue_pred;
      end
   end

   // Control state and registered commit outputs; a pending flush is honoured even if rdy_in drops.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         busy_q       <= '0;
         ready_q      <= '0;
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_val   <= '0;
         commit_tag   <= '0;
         store_valid  <= 1'b0;
         store_tag    <= '0;
         bp_update    <= 1'b0;
         bp_pc        <= '0;
         bp_taken     <= 1'b0;
         flush_out    <= 1'b0;
         redirect_pc  <= '0;
      end else begin
         commit_valid <= 1'b0;
         store_valid  <= 1'b0;
         bp_update    <= 1'b0;
         flush_out    <= 1'b0;
         if (flush_out) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
         end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            if (do_commit) begin
               case (type_q[head_q])
                  T_STORE: begin
                     store_valid <= 1'b1;
                     store_tag   <= head_q;
                  end
                  T_BRANCH: begin
                     bp_update <= 1'b1;
                     bp_pc     <= pc_q[head_q];
                     bp_taken  <= head_taken;
                     if (head_taken != pred_q[head_q]) begin
                        flush_out   <= 1'b1;
                        redirect_pc <= head_taken ? tgt_q[head_q] : pc_q[head_q] + ADDR_W'(4);
                     end
                  end
                  default: begin
                     if (rd_q[head_q] != '0) begin
                        commit_valid <= 1'b1;
                        commit_rd    <= rd_q[head_q];
                        commit_val   <= val_q[head_q];
                        commit_tag   <= head_q;
                     end
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_rob_ring.sv
// Scoreboard bench for rob_ring: a queue-of-entries reference model predicts each cycle's
// registered pulses, which a separate negedge monitor pops and compares.
module tb_rob_ring;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, rdy = 1'b1, iv = 1'b0, ipred = 1'b0;
   logic [1:0]  ity = '0;
   logic [4:0]  ird = '0;
   logic [31:0] ipc = '0, itgt = '0;
   logic [1:0]  wbv = '0;
   logic [2:0]  wbt0 = '0, wbt1 = '0;
   logic [31:0] wbval0 = '0, wbval1 = '0;
   logic [2:0]  qt1 = '0, qt2 = '0;

   logic        issue_ready, q_rdy1, q_rdy2, commit_valid, store_valid, bp_update, bp_taken;
   logic        flush_out, empty;
   logic [2:0]  issue_tag, commit_tag, store_tag;
   logic [31:0] q_val1, q_val2, commit_val, bp_pc, redirect_pc;
   logic [4:0]  commit_rd;

   rob_ring dut (
      .clk(clk), .rst_in(rst), .rdy_in(rdy),
      .issue_valid(iv), .issue_type(ity), .issue_rd(ird), .issue_pc(ipc),
      .issue_target(itgt), .issue_pred(ipred),
      .issue_ready(issue_ready), .issue_tag(issue_tag),
      .wb_valid(wbv), .wb_tag({wbt1, wbt0}), .wb_val({wbval1, wbval0}),
      .q_tag1(qt1), .q_tag2(qt2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
      .q_val1(q_val1), .q_val2(q_val2),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_tag(commit_tag), .store_valid(store_valid), .store_tag(store_tag),
      .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken),
      .flush_out(flush_out), .redirect_pc(redirect_pc), .empty(empty)
   );

   typedef struct {
      logic [2:0]  tag;
      logic [1:0]  ty;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        pred;
      logic        rdy;
      logic [31:0] val;
   } ent_t;

   typedef struct packed {
      logic        cv;
      logic [4:0]  crd;
      logic [31:0] cval;
      logic [2:0]  ctag;
      logic        sv;
      logic [2:0]  stag;
      logic        bv;
      logic [31:0] bpc;
      logic        bt;
      logic        fl;
      logic [31:0] rpc;
   } exp_t;

   ent_t rob[$];
   exp_t expq[$];
   exp_t mon_e;
   int   next_tag = 0;
   bit   flush_pend = 0;
   int   checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic lookup(input logic [2:0] t, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      foreach (rob[i]) begin
         if (rob[i].tag == t) begin
            r = rob[i].rdy;
            v = rob[i].val;
`ifdef ROB_WB_BYPASS_EN
            if (wbv[1] && wbt1 == t) begin r = 1'b1; v = wbval1; end
            else if (wbv[0] && wbt0 == t) begin r = 1'b1; v = wbval0; end
`endif
         end
      end
   endtask

   task automatic check_comb();
      logic r;
      logic [31:0] v;
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, rdy && rob.size() < DEPTH && !flush_pend});
      chk("issue_tag", {29'b0, issue_tag}, 32'(next_tag));
      chk("empty", {31'b0, empty}, {31'b0, rob.size() == 0});
      lookup(qt1, r, v);
      chk("q_rdy1", {31'b0, q_rdy1}, {31'b0, r});
      if (r) chk("q_val1", q_val1, v);
      lookup(qt2, r, v);
      chk("q_rdy2", {31'b0, q_rdy2}, {31'b0, r});
      if (r) chk("q_val2", q_val2, v);
   endtask

   task automatic apply_wb(input logic [2:0] t, input logic [31:0] v);
      foreach (rob[i]) begin
         if (rob[i].tag == t) begin
            rob[i].rdy = 1'b1;
            rob[i].val = v;
         end
      end
   endtask

   // Reference model: advance one clock edge using the inputs currently presented.
   task automatic model_edge();
      exp_t x;
      ent_t h, n;
      bit acc;
      x = '0;
      if (rst || flush_pend) begin
         rob.delete();
         next_tag = 0;
         flush_pend = 0;
      end else if (rdy) begin
         acc = iv && rob.size() < DEPTH;
         if (rob.size() > 0 && rob[0].rdy) begin
            h = rob.pop_front();
            if (h.ty == 2'b01) begin
               x.sv = 1'b1; x.stag = h.tag;
            end else if (h.ty == 2'b10) begin
               x.bv = 1'b1; x.bpc = h.pc; x.bt = h.val[0];
               if (h.val[0] != h.pred) begin
                  x.fl = 1'b1;
                  x.rpc = h.val[0] ? h.tgt : h.pc + 32'd4;
                  flush_pend = 1;
               end
            end else if (h.rd != 0) begin
               x.cv = 1'b1; x.crd = h.rd; x.cval = h.val; x.ctag = h.tag;
            end
         end
         if (wbv[0]) apply_wb(wbt0, wbval0);
         if (wbv[1]) apply_wb(wbt1, wbval1);
         if (acc) begin
            n.tag = 3'(next_tag); n.ty = ity; n.rd = ird; n.pc = ipc; n.tgt = itgt;
            n.pred = ipred; n.rdy = 1'b0; n.val = '0;
            rob.push_back(n);
            next_tag = (next_tag + 1) % DEPTH;
         end
      end
      expq.push_back(x);
   endtask

   task automatic tick();
      #1;
      if (!rst) check_comb();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      rdy = 1'b1; iv = 1'b0; ity = '0; ird = '0; ipc = '0; itgt = '0; ipred = 1'b0;
      wbv = '0; wbt0 = '0; wbt1 = '0; wbval0 = '0; wbval1 = '0; qt1 = '0; qt2 = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] tg, input logic pr);
      idle();
      iv = 1'b1; ity = t; ird = rd; ipc = pc; itgt = tg; ipred = pr;
      tick();
   endtask

   // Write back the oldest not-yet-ready entries until the buffer empties.
   task automatic drain();
      int k;
      for (int cyc = 0; cyc < 40 && (rob.size() > 0 || flush_pend); cyc++) begin
         idle();
         k = 0;
         foreach (rob[i]) begin
            if (!rob[i].rdy && k < 2) begin
               if (k == 0) begin wbv[0] = 1'b1; wbt0 = rob[i].tag; wbval0 = $urandom; end
               else begin wbv[1] = 1'b1; wbt1 = rob[i].tag; wbval1 = $urandom; end
               k++;
            end
         end
         tick();
      end
      chk("drain_done", 32'(rob.size()), 32'd0);
      idle();
      tick();
   endtask

   task automatic rand_inputs();
      int sel;
      rdy = ($urandom_range(0, 9) != 0);
      iv = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      ity = (sel < 5) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      ird = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      ipc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      itgt = $urandom;
      ipred = 1'($urandom_range(0, 1));
      wbv = 2'($urandom_range(0, 3));
      wbt0 = (rob.size() > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, rob.size()-1)].tag : 3'($urandom);
      wbt1 = (rob.size() > 0 && $urandom_range(0, 3) != 0) ? rob[$urandom_range(0, rob.size()-1)].tag : 3'($urandom);
      if ($urandom_range(0, 7) == 0) wbt1 = wbt0;
      wbval0 = $urandom;
      wbval1 = $urandom;
      qt1 = (rob.size() > 0 && $urandom_range(0, 1) != 0) ? rob[$urandom_range(0, rob.size()-1)].tag : 3'($urandom);
      qt2 = (rob.size() > 0 && $urandom_range(0, 1) != 0) ? rob[$urandom_range(0, rob.size()-1)].tag : 3'($urandom);
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         chk("commit_valid", {31'b0, commit_valid}, {31'b0, mon_e.cv});
         if (mon_e.cv) begin
            chk("commit_rd", {27'b0, commit_rd}, {27'b0, mon_e.crd});
            chk("commit_val", commit_val, mon_e.cval);
            chk("commit_tag", {29'b0, commit_tag}, {29'b0, mon_e.ctag});
         end
         chk("store_valid", {31'b0, store_valid}, {31'b0, mon_e.sv});
         if (mon_e.sv) chk("store_tag", {29'b0, store_tag}, {29'b0, mon_e.stag});
         chk("bp_update", {31'b0, bp_update}, {31'b0, mon_e.bv});
         if (mon_e.bv) begin
            chk("bp_pc", bp_pc, mon_e.bpc);
            chk("bp_taken", {31'b0, bp_taken}, {31'b0, mon_e.bt});
         end
         chk("flush_out", {31'b0, flush_out}, {31'b0, mon_e.fl});
         if (mon_e.fl) chk("redirect_pc", redirect_pc, mon_e.rpc);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      @(negedge clk);
      do_reset();
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_issue_tag", {29'b0, issue_tag}, 32'd0);
      chk("rst_commit_rd", {27'b0, commit_rd}, 32'd0);
      chk("rst_commit_val", commit_val, 32'd0);
      chk("rst_bp_pc", bp_pc, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);

      // Fill with nine REG issues: the ninth must be refused.
      for (int i = 0; i < 9; i++) issue(2'b00, 5'(i + 1), 32'(i * 4), '0, 1'b0);
      chk("full_tail_wrapped", {29'b0, issue_tag}, 32'd0);
      chk("full_not_empty", {31'b0, empty}, 32'd0);
      drain();

      // Out-of-order write-back, in-order commit.
      do_reset();
      issue(2'b00, 5'd5, 32'h10, '0, 1'b0);
      issue(2'b00, 5'd6, 32'h14, '0, 1'b0);
      idle(); wbv = 2'b01; wbt0 = 3'd1; wbval0 = 32'h22; tick();
      idle(); wbv = 2'b01; wbt0 = 3'd0; wbval0 = 32'h11; tick();
      for (int i = 0; i < 3; i++) begin idle(); tick(); end

      // Two channels hit the same tag: highest channel wins.
      do_reset();
      for (int i = 0; i < 4; i++) issue(2'b00, 5'(7 + i), 32'(i * 4), '0, 1'b0);
      idle(); wbv = 2'b11; wbt0 = 3'd3; wbt1 = 3'd3; wbval0 = 32'hA; wbval1 = 32'hB; tick();
      drain();

      // Mispredicted branch produces flush and redirect.
      do_reset();
      issue(2'b10, 5'd0, 32'h100, 32'h180, 1'b0);
      idle(); wbv = 2'b01; wbt0 = 3'd0; wbval0 = 32'h1; tick();
      for (int i = 0; i < 3; i++) begin idle(); tick(); end
      chk("post_flush_empty", {31'b0, empty}, 32'd1);
      chk("post_flush_tag", {29'b0, issue_tag}, 32'd0);

      // Full buffer: commit and issue in the same cycle, issue refused then accepted.
      do_reset();
      for (int i = 0; i < 8; i++) issue(2'b01, 5'd1, 32'(i * 4), '0, 1'b0);
      idle(); iv = 1'b1; wbv = 2'b01; wbt0 = 3'd0; wbval0 = 32'h5; tick();
      issue(2'b00, 5'd9, 32'h40, '0, 1'b0);
      issue(2'b00, 5'd10, 32'h44, '0, 1'b0);
      drain();

      // Lookup visibility of a write-back.
      do_reset();
      for (int i = 0; i < 3; i++) issue(2'b00, 5'(i + 1), 32'(i * 4), '0, 1'b0);
      idle(); wbv = 2'b01; wbt0 = 3'd2; wbval0 = 32'h55; qt1 = 3'd2; tick();
      idle(); qt1 = 3'd2; tick();
      drain();

      // Random traffic with occasional reset.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else begin
            rand_inputs();
            tick();
         end
      end
      drain();
      idle(); tick();
      #1;
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
